// File: rtl/hangman_pkg.sv
// ============================================================================
//  Module      : hangman_pkg
//  Description : Shared hangman constants and scanner state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hangman_pkg;

   localparam int CHAR_W     = 8;
   localparam int MAX_LEN    = 16;
   localparam int MAX_MISSES = 6;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/guess_scanner_popcount.sv
// ============================================================================
//  Module      : mask_popcount
//  Description : Combinational count of set bits in the reveal mask.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mask_popcount #(
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 5
) (
   input  logic [MAX_LEN-1:0] mask_i,
   output logic [CNT_W-1:0]   count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         count_o = count_o + CNT_W'(mask_i[i]);
      end
   end

endmodule

`default_nettype wire

// File: rtl/guess_scanner.sv
// ============================================================================
//  Module      : guess_scanner
//  Description : Scans the stored word per guess, maintains reveal mask,
//                miss count and win/lose status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module guess_scanner #(
   parameter int MAX_LEN    = hangman_pkg::MAX_LEN,
   parameter int ADDR_W     = 4,
   parameter int CHAR_W     = hangman_pkg::CHAR_W,
   parameter int MAX_MISSES = hangman_pkg::MAX_MISSES
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                clear,
   input  logic                start,
   input  logic [CHAR_W-1:0]   guess,
   input  logic [ADDR_W:0]     word_len,
   output logic                mem_rden,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [CHAR_W-1:0]   mem_q,
   output logic                busy,
   output logic                done,
   output logic                match,
   output logic                repeat_g,
   output logic [MAX_LEN-1:0]  reveal_mask,
   output logic [ADDR_W:0]     remaining,
   output logic [2:0]          misses,
   output logic                complete,
   output logic                lost
);

   import hangman_pkg::S_IDLE;
   import hangman_pkg::S_SCAN;
   import hangman_pkg::S_DRAIN;
   import hangman_pkg::S_DONE;

   localparam int               LEN_W    = ADDR_W + 1;
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [2:0]       MISS_MAX = 3'(MAX_MISSES);

   logic [1:0]         state_q, state_d;
   logic [CHAR_W-1:0]  guess_q;
   logic [LEN_W-1:0]   len_q, idx_q;
   logic [ADDR_W-1:0]  addr_q, tag_q;
   logic               tag_vld_q;
   logic               hit_q, hit_d, new_q, new_d;
   logic [MAX_LEN-1:0] mask_q, mask_d;
   logic               match_q, repeat_q, complete_q, lost_q;
   logic [LEN_W-1:0]   remaining_q, rem_d, pop;
   logic [2:0]         misses_q, misses_d;
   logic               issue, accept, cmp_hit;

   assign issue   = (state_q == S_SCAN);
   assign accept  = (state_q == S_IDLE) && start && !complete_q && !lost_q;
   assign cmp_hit = tag_vld_q && (mem_q == guess_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = (word_len == '0) ? S_DRAIN : S_SCAN;
         S_SCAN:  if (idx_q == len_q - LEN_ONE) state_d = S_DRAIN;
         S_DRAIN: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // The final compare lands in S_DRAIN, so results are taken from next-state values.
   always_comb begin
      mask_d = mask_q;
      hit_d  = hit_q;
      new_d  = new_q;
      if (cmp_hit) begin
         hit_d = 1'b1;
         if (!mask_q[tag_q]) begin
            mask_d[tag_q] = 1'b1;
            new_d         = 1'b1;
         end
      end
   end

   mask_popcount #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (LEN_W)
   ) u_popcount (
      .mask_i  (mask_d),
      .count_o (pop)
   );

   always_comb begin
      rem_d    = len_q - pop;
      misses_d = misses_q;
      if (!hit_d && (len_q != '0) && (misses_q != MISS_MAX)) misses_d = misses_q + 3'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         guess_q     <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         addr_q      <= '0;
         tag_q       <= '0;
         tag_vld_q   <= 1'b0;
         hit_q       <= 1'b0;
         new_q       <= 1'b0;
         mask_q      <= '0;
         match_q     <= 1'b0;
         repeat_q    <= 1'b0;
         remaining_q <= '0;
         misses_q    <= '0;
         complete_q  <= 1'b0;
         lost_q      <= 1'b0;
      end else if (clear) begin
         state_q     <= S_IDLE;
         tag_vld_q   <= 1'b0;
         hit_q       <= 1'b0;
         new_q       <= 1'b0;
         mask_q      <= '0;
         match_q     <= 1'b0;
         repeat_q    <= 1'b0;
         remaining_q <= '0;
         misses_q    <= '0;
         complete_q  <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         tag_vld_q <= issue;
         tag_q     <= idx_q[ADDR_W-1:0];
         mask_q    <= mask_d;
         if (issue) addr_q <= idx_q[ADDR_W-1:0];
         if (accept) begin
            guess_q <= guess;
            len_q   <= word_len;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            new_q   <= 1'b0;
         end else begin
            if (issue) idx_q <= idx_q + LEN_ONE;
            hit_q <= hit_d;
            new_q <= new_d;
         end
         if (state_q == S_DRAIN) begin
            match_q     <= new_d;
            repeat_q    <= hit_d && !new_d;
            misses_q    <= misses_d;
            remaining_q <= rem_d;
            complete_q  <= (rem_d == '0);
            lost_q      <= (misses_d == MISS_MAX);
         end
      end
   end

   assign mem_rden    = issue;
   assign mem_addr    = issue ? idx_q[ADDR_W-1:0] : addr_q;
   assign busy        = (state_q == S_SCAN) || (state_q == S_DRAIN);
   assign done        = (state_q == S_DONE);
   assign match       = match_q;
   assign repeat_g    = repeat_q;
   assign reveal_mask = mask_q;
   assign remaining   = remaining_q;
   assign misses      = misses_q;
   assign complete    = complete_q;
   assign lost        = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_guess_scanner.sv
// ============================================================================
//  Module      : tb_guess_scanner
//  Description : Randomized scoreboard bench for guess_scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_guess_scanner;

   localparam int MAX_LEN = 16;
   localparam int MAX_MIS = 6;

   logic        clk = 1'b0;
   logic        resetn, clear, start;
   logic [7:0]  guess;
   logic [4:0]  word_len;
   logic        mem_rden;
   logic [3:0]  mem_addr;
   logic [7:0]  mem_q = '0;
   logic        busy, done, match, repeat_g, complete, lost;
   logic [15:0] reveal_mask;
   logic [4:0]  remaining;
   logic [2:0]  misses;

   always #5 clk = ~clk;

   guess_scanner dut (
      .clk         (clk),
      .resetn      (resetn),
      .clear       (clear),
      .start       (start),
      .guess       (guess),
      .word_len    (word_len),
      .mem_rden    (mem_rden),
      .mem_addr    (mem_addr),
      .mem_q       (mem_q),
      .busy        (busy),
      .done        (done),
      .match       (match),
      .repeat_g    (repeat_g),
      .reveal_mask (reveal_mask),
      .remaining   (remaining),
      .misses      (misses),
      .complete    (complete),
      .lost        (lost)
   );

   logic [7:0] word [MAX_LEN];
   always @(posedge clk) if (mem_rden) mem_q <= word[mem_addr];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned at;
      logic        mt, rp, cp, ls;
      logic [15:0] mask;
      logic [4:0]  rem;
      logic [2:0]  mis;
   } exp_t;
   exp_t sbq[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Game model: revealed positions as a plain bit set.
   bit [15:0] m_mask;
   int        m_miss;
   bit        m_comp, m_lost;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (done) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("done_cycle", cyc, e.at);
               chk("match", match, e.mt);
               chk("repeat_g", repeat_g, e.rp);
               chk("reveal_mask", reveal_mask, e.mask);
               chk("remaining", remaining, e.rem);
               chk("misses", misses, e.mis);
               chk("complete", complete, e.cp);
               chk("lost", lost, e.ls);
            end
         end else if (sbq.size() != 0 && cyc > sbq[0].at) begin
            chk("missing_done", 32'd0, 32'd1);
            void'(sbq.pop_front());
         end
      end
   end

   task automatic model_clear();
      m_mask = '0; m_miss = 0; m_comp = 1'b0; m_lost = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_clear();
   endtask

   // Called just after a rising edge; that cycle is cycle 0 of the guess.
   task automatic do_start(input logic [7:0] g, input int len, input bit poke);
      exp_t e;
      bit   acc, hit, nw;
      int   rem;
      acc = !m_comp && !m_lost;
      hit = 1'b0; nw = 1'b0;
      if (acc) begin
         for (int i = 0; i < len; i++) begin
            if (word[i] == g) begin
               hit = 1'b1;
               if (!m_mask[i]) begin
                  nw = 1'b1;
                  m_mask[i] = 1'b1;
               end
            end
         end
         if (!hit && len != 0 && m_miss < MAX_MIS) m_miss++;
         rem    = len - $countones(m_mask);
         m_comp = (rem == 0);
         m_lost = (m_miss == MAX_MIS);
         e.at   = cyc + len + 2;
         e.mt   = nw;
         e.rp   = hit && !nw;
         e.mask = m_mask;
         e.rem  = 5'(rem);
         e.mis  = 3'(m_miss);
         e.cp   = m_comp;
         e.ls   = m_lost;
         sbq.push_back(e);
      end
      guess = g; word_len = 5'(len); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      word_len = 5'($urandom_range(0, 16));
      guess = 8'($urandom);
      @(negedge clk);
      chk("busy_cycle1", busy, acc);
      @(posedge clk); #1;
      if (poke) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (len) @(posedge clk);
      end else begin
         repeat (len + 1) @(posedge clk);
      end
      #1;
   endtask

   task automatic load_word(input string s);
      for (int i = 0; i < MAX_LEN; i++) word[i] = (i < s.len()) ? s[i] : 8'h2E;
   endtask

   initial begin
      int len;
      resetn = 1'b0; clear = 1'b0; start = 1'b0; guess = '0; word_len = '0;
      model_clear();
      load_word("APPLE");
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {busy, done, match, repeat_g, complete, lost, mem_rden,
                            reveal_mask, remaining, misses}, 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      do_start("P", 5, 1'b0);
      do_start("P", 5, 1'b0);
      for (int k = 0; k < 7; k++) do_start("Z", 5, 1'b0);
      chk("lost_hold", lost, 1'b1);

      pulse_clear();
      do_start("A", 5, 1'b0);
      do_start("P", 5, 1'b1);
      do_start("L", 5, 1'b0);
      do_start("E", 5, 1'b0);
      do_start("A", 5, 1'b0);
      chk("complete_hold", complete, 1'b1);

      // Mid-scan clear must drop the scan without a done pulse.
      pulse_clear();
      do_start("Z", 5, 1'b0);
      guess = "P"; word_len = 5'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_clear();
      @(negedge clk);
      chk("clear_state", {busy, reveal_mask, misses, match, lost, complete}, 32'd0);
      repeat (8) @(posedge clk);
      #1;

      // Asynchronous reset mid-scan.
      do_start("A", 5, 1'b0);
      guess = "P"; word_len = 5'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #3;
      resetn = 1'b0;
      #1;
      chk("async_reset", {busy, done, match, repeat_g, complete, lost, mem_rden,
                          reveal_mask, remaining, misses}, 32'd0);
      model_clear();
      @(posedge clk); #2;
      resetn = 1'b1;
      @(posedge clk); #1;
      do_start("A", 0, 1'b0);
      pulse_clear();

      for (int gm = 0; gm < 8; gm++) begin
         len = $urandom_range(1, MAX_LEN);
         for (int i = 0; i < MAX_LEN; i++) word[i] = 8'("A" + $urandom_range(0, 5));
         pulse_clear();
         for (int k = 0; k < 20; k++)
            do_start(8'("A" + $urandom_range(0, 7)), len, ($urandom_range(0, 3) == 0));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
